// File: rtl/race_pkg.sv
// race_pkg: shared state encoding, coordinate width and default geometry
// for race_traffic_ctrl and its LFSR.
package race_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CRASH = 2'd2} state_t;
  localparam int XY_W = 10;
  localparam int DEF_LANE_X0 = 197;
  localparam int DEF_LANE_PITCH = 82;
  localparam int DEF_CAR_W = 80;
  localparam int DEF_CAR_H = 121;
  localparam int DEF_Y_END = 620;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
endpackage

// File: rtl/race_lfsr.sv
// race_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick spawn lanes.
module race_lfsr
  import race_pkg::*;
(
  input  logic        clk50mhz,
  input  logic        reset,
  output logic [15:0] q
);
  logic [15:0] q_q, q_d;
  always_comb q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
  always_ff @(posedge clk50mhz or negedge reset)
    if (!reset) q_q <= LFSR_SEED;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/race_traffic_ctrl.sv
// race_traffic_ctrl: enemy-car traffic for a lane racer -- spawning, motion, speed ramp and crash detection.
// Define RACE_SCORE_EN to add the score output counting cars that leave the screen.
module race_traffic_ctrl
  import race_pkg::*;
#(
  parameter int N_SLOTS    = 4,
  parameter int N_LANES    = 3,
  parameter int LANE_X0    = DEF_LANE_X0,
  parameter int LANE_PITCH = DEF_LANE_PITCH,
  parameter int CAR_W      = DEF_CAR_W,
  parameter int CAR_H      = DEF_CAR_H,
  parameter int Y_END      = DEF_Y_END,
  parameter int SPAWN_GAP  = 270,
  parameter int RAMP_TICKS = 300,
  parameter int SPEED_MAX  = 8
) (
  input  logic                    clk50mhz,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    start,
  input  logic [XY_W-1:0]         player_x,
  input  logic [XY_W-1:0]         player_y,
  output logic [N_SLOTS*XY_W-1:0] enemy_x,
  output logic [N_SLOTS*XY_W-1:0] enemy_y,
  output logic [N_SLOTS-1:0]      enemy_act,
  output logic [3:0]              speed,
  output logic                    crash,
  output logic [1:0]              state
`ifdef RACE_SCORE_EN
  ,
  output logic [15:0]             score
`endif
);
  localparam logic [15:0] GAP = 16'(SPAWN_GAP);
  localparam logic [15:0] RAMP = 16'(RAMP_TICKS);
  localparam logic [3:0] SPD_MAX = 4'(SPEED_MAX);
  typedef logic [N_SLOTS-1:0][XY_W-1:0] pos_t;
  state_t state_q, state_d;
  pos_t ex_q, ex_d, ey_q, ey_d;
  logic [N_SLOTS-1:0] act_q, act_d;
  logic [3:0] speed_q, speed_d;
  logic crash_q, crash_d;
  logic [15:0] spawn_q, spawn_d, ramp_q, ramp_d;
  logic [15:0] lfsr;
  logic unused_lfsr;
  logic hit, run_tick, slot_ok, lane_ok;
  logic [XY_W:0] dx, dy, sum;
  logic [N_LANES-1:0] blocked;
  int slot, lane, cand;
  function automatic logic [XY_W-1:0] lane_x(int l);
    return XY_W'(LANE_X0 + l * LANE_PITCH);
  endfunction
  race_lfsr u_lfsr (.clk50mhz(clk50mhz), .reset(reset), .q(lfsr));
  assign unused_lfsr = ^lfsr[15:8];
  always_comb begin
    hit = 1'b0;
    dx = '0;
    dy = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      dx = ex_q[i] >= player_x ? {1'b0, ex_q[i]} - {1'b0, player_x} : {1'b0, player_x} - {1'b0, ex_q[i]};
      dy = ey_q[i] >= player_y ? {1'b0, ey_q[i]} - {1'b0, player_y} : {1'b0, player_y} - {1'b0, ey_q[i]};
      if (act_q[i] && dx < (XY_W+1)'(CAR_W) && dy < (XY_W+1)'(CAR_H)) hit = 1'b1;
    end
  end
  // Lane occupancy uses pre-move positions; lane search walks up from the random candidate.
  always_comb begin
    blocked = '0;
    slot = 0;
    slot_ok = 1'b0;
    lane = 0;
    lane_ok = 1'b0;
    cand = int'(lfsr[7:0]) % N_LANES;
    for (int l = 0; l < N_LANES; l++)
      for (int i = 0; i < N_SLOTS; i++)
        if (act_q[i] && ex_q[i] == lane_x(l) && ey_q[i] < XY_W'(CAR_H)) blocked[l] = 1'b1;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (!act_q[i]) begin
        slot = i;
        slot_ok = 1'b1;
      end
    for (int k = N_LANES - 1; k >= 0; k--)
      for (int l = 0; l < N_LANES; l++)
        if (l == (cand + k) % N_LANES && !blocked[l]) begin
          lane = l;
          lane_ok = 1'b1;
        end
  end
  always_comb begin
    state_d = state_q;
    ex_d = ex_q;
    ey_d = ey_q;
    act_d = act_q;
    speed_d = speed_q;
    crash_d = crash_q;
    spawn_d = spawn_q;
    ramp_d = ramp_q;
    sum = '0;
    run_tick = state_q == RUN && tick && !hit;
    if (state_q != RUN && start) begin
      state_d = RUN;
      ex_d = '0;
      ey_d = '0;
      act_d = '0;
      speed_d = 4'd1;
      crash_d = 1'b0;
      spawn_d = '0;
      ramp_d = '0;
    end else if (state_q == RUN && hit) begin
      state_d = CRASH;
      crash_d = 1'b1;
    end else if (run_tick) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        sum = {1'b0, ey_q[i]} + (XY_W+1)'(speed_q);
        if (act_q[i] && sum >= (XY_W+1)'(Y_END)) act_d[i] = 1'b0;
        else if (act_q[i]) ey_d[i] = sum[XY_W-1:0];
      end
      spawn_d = spawn_q + 16'd1;
      if (spawn_d >= GAP) begin
        spawn_d = slot_ok && lane_ok ? '0 : GAP;
        for (int i = 0; i < N_SLOTS; i++)
          if (slot_ok && lane_ok && i == slot) begin
            act_d[i] = 1'b1;
            ex_d[i] = lane_x(lane);
            ey_d[i] = '0;
          end
      end
      if (ramp_q + 16'd1 >= RAMP) begin
        ramp_d = '0;
        speed_d = speed_q < SPD_MAX ? speed_q + 4'd1 : speed_q;
      end else ramp_d = ramp_q + 16'd1;
    end
  end
  always_ff @(posedge clk50mhz or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      ex_q <= '0;
      ey_q <= '0;
      act_q <= '0;
      speed_q <= 4'd1;
      crash_q <= 1'b0;
      spawn_q <= '0;
      ramp_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q <= ex_d;
      ey_q <= ey_d;
      act_q <= act_d;
      speed_q <= speed_d;
      crash_q <= crash_d;
      spawn_q <= spawn_d;
      ramp_q <= ramp_d;
    end
`ifdef RACE_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;
  logic [3:0] n_exit;
  always_comb begin
    n_exit = '0;
    for (int i = 0; i < N_SLOTS; i++)
      if (run_tick && act_q[i] && {1'b0, ey_q[i]} + (XY_W+1)'(speed_q) >= (XY_W+1)'(Y_END)) n_exit = n_exit + 4'd1;
    score_sum = {1'b0, score_q} + 17'(n_exit);
    score_d = state_q != RUN && start ? '0 : score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
  always_ff @(posedge clk50mhz or negedge reset)
    if (!reset) score_q <= '0;
    else score_q <= score_d;
  assign score = score_q;
`endif
  assign enemy_x = ex_q;
  assign enemy_y = ey_q;
  assign enemy_act = act_q;
  assign speed = speed_q;
  assign crash = crash_q;
  assign state = state_q;
endmodule

// File: tb/tb_race_traffic_ctrl.sv
// tb_race_traffic_ctrl: directed scoreboard bench; dut uses default geometry, dut2 a short spawn gap
// so lane blocking, three-slot reset and the crash scenario are reachable quickly.
module tb_race_traffic_ctrl;
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic r1, r2, tick, start;
  logic [9:0] px, py;
  logic [39:0] ex1, ey1, ex2, ey2;
  logic [3:0] act1, act2, spd1, spd2;
  logic cr1, cr2;
  logic [1:0] st1, st2;
`ifdef RACE_SCORE_EN
  logic [15:0] sc1, sc2;
`endif
  race_traffic_ctrl dut (
    .clk50mhz(clk), .reset(r1), .tick(tick), .start(start), .player_x(px), .player_y(py),
    .enemy_x(ex1), .enemy_y(ey1), .enemy_act(act1), .speed(spd1), .crash(cr1), .state(st1)
`ifdef RACE_SCORE_EN
    , .score(sc1)
`endif
  );
  race_traffic_ctrl #(.SPAWN_GAP(20), .RAMP_TICKS(1000)) dut2 (
    .clk50mhz(clk), .reset(r2), .tick(tick), .start(start), .player_x(px), .player_y(py),
    .enemy_x(ex2), .enemy_y(ey2), .enemy_act(act2), .speed(spd2), .crash(cr2), .state(st2)
`ifdef RACE_SCORE_EN
    , .score(sc2)
`endif
  );
  string tag_q[$];
  logic [63:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  bit m_act[4];
  int m_y[4];
  int m_spd, m_cnt, m_ramp, m_score, new_slot;
  task automatic expect_v(string t, logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask
  task automatic check_v(logic [63:0] obs);
    string t;
    logic [63:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", t, obs, e);
    end
  endtask
  task automatic chk(string t, logic [63:0] obs, logic [63:0] e);
    expect_v(t, e);
    check_v(obs);
  endtask
  function automatic logic [9:0] sl(logic [39:0] v, int i);
    return v[10*i +: 10];
  endfunction
  function automatic bit in_lane(logic [9:0] x);
    return x == 10'd197 || x == 10'd279 || x == 10'd361;
  endfunction
  function automatic bit lane1_at(int y);
    for (int i = 0; i < 4; i++)
      if (act2[i] && sl(ex2, i) == 10'd279 && int'(sl(ey2, i)) == y) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_y[i] = 0; end
    m_spd = 1; m_cnt = 0; m_ramp = 0; m_score = 0; new_slot = -1;
  endtask
  // Reference behaviour for dut: lanes are never blocked at a 270-tick gap, so lane choice is ignored.
  task automatic model_tick();
    bit pre[4];
    int fs;
    pre = m_act;
    fs = -1;
    new_slot = -1;
    for (int i = 0; i < 4; i++)
      if (m_act[i]) begin
        if (m_y[i] + m_spd >= 620) begin
          m_act[i] = 0;
          if (m_score < 65535) m_score++;
        end else m_y[i] += m_spd;
      end
    for (int i = 3; i >= 0; i--) if (!pre[i]) fs = i;
    m_cnt++;
    if (m_cnt >= 270) begin
      if (fs >= 0) begin m_act[fs] = 1; m_y[fs] = 0; m_cnt = 0; new_slot = fs; end
      else m_cnt = 270;
    end
    m_ramp++;
    if (m_ramp == 300) begin m_ramp = 0; if (m_spd < 8) m_spd++; end
  endtask
  task automatic run1(int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      model_tick();
      @(negedge clk);
    end
    tick = 1'b0;
  endtask
  task automatic run_plain(int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask
  task automatic check1(string t);
    logic [3:0] ea;
    ea = '0;
    for (int i = 0; i < 4; i++) ea[i] = m_act[i];
    expect_v({t, " act"}, ea);
    expect_v({t, " speed"}, m_spd);
    for (int i = 0; i < 4; i++) if (m_act[i]) expect_v($sformatf("%s y%0d", t, i), m_y[i]);
`ifdef RACE_SCORE_EN
    expect_v({t, " score"}, m_score);
`endif
    check_v(act1);
    check_v(spd1);
    for (int i = 0; i < 4; i++) if (m_act[i]) check_v(sl(ey1, i));
`ifdef RACE_SCORE_EN
    check_v(sc1);
`endif
    if (new_slot >= 0) chk({t, " spawn x in lane"}, in_lane(sl(ex1, new_slot)), 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bit got, prev_ov;
    r1 = 0; r2 = 0; tick = 0; start = 0; px = 10'd0; py = 10'd1000;
    repeat (2) @(negedge clk);
    chk("in reset state", st1, 0);
    chk("in reset speed", spd1, 1);
    r1 = 1; r2 = 1;
    @(negedge clk);
    chk("post reset act", act1, 0);
    chk("post reset x", ex1, 0);
    chk("post reset y", ey1, 0);
    chk("post reset crash", cr1, 0);
    run_plain(5);
    chk("idle tick state", st1, 0);
    chk("idle tick act", act1, 0);
    start = 1; @(negedge clk); start = 0;
    model_clear();
    chk("start state", st1, 1);
    run1(269); check1("t269");
    run1(1);   check1("t270");
    run1(270); check1("t540");
    run1(54);  check1("t594");
    chk("t594 slot0 y", sl(ey1, 0), 618);
    chk("t594 speed", spd1, 2);
    run1(1);   check1("t595");
    chk("t595 slot0 exited", act1[0], 0);
    chk("t595 slot0 y held", sl(ey1, 0), 618);
`ifdef RACE_SCORE_EN
    chk("t595 score", sc1, 1);
`endif
    run1(215);  check1("t810");
    run1(270);  check1("t1080");
    run1(1020); check1("t2100");
    chk("t2100 speed max", spd1, 8);
    run1(300);  check1("t2400");
    chk("t2400 speed held", spd1, 8);
    // dut2: three lanes fill, fourth car waits for a clear lane
    r2 = 0; @(negedge clk); r2 = 1; @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    run_plain(80);
    chk("blk t80 act", act2, 4'b0111);
    chk("blk t80 y0", sl(ey2, 0), 60);
    chk("blk t80 y1", sl(ey2, 1), 40);
    chk("blk t80 y2", sl(ey2, 2), 20);
    chk("blk lanes distinct", sl(ex2, 0) != sl(ex2, 1) && sl(ex2, 1) != sl(ex2, 2) && sl(ex2, 0) != sl(ex2, 2), 1);
    chk("blk lanes valid", in_lane(sl(ex2, 0)) && in_lane(sl(ex2, 1)) && in_lane(sl(ex2, 2)), 1);
    run_plain(61);
    chk("blk t141 act", act2, 4'b0111);
    chk("blk t141 y0", sl(ey2, 0), 121);
    run_plain(1);
    chk("blk t142 act", act2, 4'b1111);
    chk("blk t142 y3", sl(ey2, 3), 0);
    chk("blk t142 lane of slot0", sl(ex2, 3) == sl(ex2, 0), 1);
    chk("blk t142 y0", sl(ey2, 0), 122);
    // asynchronous reset in the middle of RUN
    r2 = 0; @(negedge clk); r2 = 1; @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    run_plain(80);
    chk("mid pre act2", act2, 4'b0111);
    chk("mid pre speed1", spd1, 8);
    #3; r1 = 0; r2 = 0; #1;
    chk("mid rst act2", act2, 0);
    chk("mid rst state2", st2, 0);
    chk("mid rst y2", ey2, 0);
    chk("mid rst act1", act1, 0);
    chk("mid rst state1", st1, 0);
    chk("mid rst speed1", spd1, 1);
    @(negedge clk); r1 = 1; r2 = 1;
    // crash against a lane-1 enemy
    px = 10'd279; py = 10'd357;
    @(negedge clk); start = 1; @(negedge clk); start = 0;
    got = 0; prev_ov = 0;
    tick = 1;
    for (int c = 0; c < 1500 && !got; c++) begin
      @(negedge clk);
      if (cr2) got = 1;
      else prev_ov = lane1_at(237);
    end
    chk("crash seen", got, 1);
    chk("crash one cycle after overlap", prev_ov, 1);
    chk("crash state", st2, 2);
    chk("crash y at 237", lane1_at(237), 1);
    repeat (5) @(negedge clk);
    tick = 0;
    chk("crash y frozen", lane1_at(237), 1);
    chk("crash held", cr2, 1);
    chk("crash state held", st2, 2);
    start = 1; @(negedge clk); start = 0;
    chk("restart state", st2, 1);
    chk("restart crash", cr2, 0);
    chk("restart act", act2, 0);
    chk("restart speed", spd2, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/race_traffic_ctrl.md
RACE_TRAFFIC_CTRL -- requirements
Module: race_traffic_ctrl

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4, number of enemy car slots (1..8).
REQ-002 SHALL have parameter N_LANES, default 3, number of lanes (2..4).
REQ-003 SHALL have parameters LANE_X0 = 197, LANE_PITCH = 82, CAR_W = 80, CAR_H = 121, Y_END = 620: lane-0 x, lane spacing, car box size and exit row, all in pixels.
REQ-004 SHALL have parameters SPAWN_GAP = 270, RAMP_TICKS = 300 and SPEED_MAX = 8, counted in ticks or pixels per tick.
REQ-005 SHALL have port clk50mhz  in  1  sole clock; all logic is rising-edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port tick  in  1  one-cycle motion-step pulse.
REQ-008 SHALL have port start  in  1  level, sampled every cycle.
REQ-009 SHALL have ports player_x and player_y  in  10 each  player car top-left.
REQ-010 SHALL have ports enemy_x and enemy_y  out  N_SLOTS*10 each  slot i at bits [10i+9:10i].
REQ-011 SHALL have port enemy_act  out  N_SLOTS  per-slot active flag.
REQ-012 SHALL have ports speed  out  4  current pixels/tick; crash  out  1; state  out  2.

Function
REQ-013 SHALL implement an FSM with states IDLE=0, RUN=1, CRASH=2.
- IDLE->RUN on start=1: all slots cleared, speed=1, counters zeroed.
- RUN->CRASH on a registered hit.
- CRASH->RUN on start=1, with the same clearing as IDLE->RUN.
REQ-014 SHALL advance positions, spawn and ramp only in RUN and only in a cycle with tick=1; all other states freeze every output.
REQ-015 SHALL add speed to each active slot's y on a RUN tick; if y+speed >= Y_END, the slot SHALL clear enemy_act, and its y SHALL hold the old value.
REQ-016 SHALL count RUN ticks in a spawn counter; at >= SPAWN_GAP it SHALL spawn into the lowest-index free slot with y=0 and x=LANE_X0+lane*LANE_PITCH, then reset the counter to 0.
REQ-017 SHALL take the candidate lane as lfsr[7:0] mod N_LANES; while that lane holds an active car with y < CAR_H, it SHALL try lane+1 (wrapping at N_LANES), at most N_LANES tries.
REQ-018 SHALL skip the spawn when no slot is free or no lane is clear; the counter SHALL then saturate at SPAWN_GAP and retry on every following tick.
REQ-019 SHALL NOT spawn into a slot on the tick that slot exits.
REQ-020 SHALL increment speed every RAMP_TICKS RUN ticks, saturating at SPEED_MAX.
REQ-021 SHALL evaluate the hit every cycle as: any active slot with |ex-px| < CAR_W and |ey-py| < CAR_H, using 11-bit unsigned differences.
REQ-022 SHALL register the hit into crash with one cycle latency; crash stays 1 throughout CRASH.
REQ-023 SHALL give the hit priority over a tick in the same cycle, so positions do not advance.
REQ-024 SHALL clock the LFSR every cycle in all states: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, never zero.

Reset
REQ-025 SHALL, on reset=0 (asynchronous), force state=IDLE, enemy_act=0, enemy_x=0, enemy_y=0, speed=1, crash=0, counters=0 and lfsr=16'hACE1.
REQ-026 SHALL release reset synchronously; the first tick after release in IDLE has no effect.

Configuration
REQ-027 SHALL, with RACE_SCORE_EN defined, add port score  out  16: +1 per slot exiting at Y_END, counting multiple exits in the same tick, saturating at 16'hFFFF, cleared on IDLE->RUN and CRASH->RUN, and reset to 0.
REQ-028 SHALL, without RACE_SCORE_EN, have no score port and no score logic.

Structure
REQ-029 SHALL place the state encoding, the Y/X width (10) and the default geometry constants in shared package race_pkg.
REQ-030 SHALL implement the LFSR as sub-module race_lfsr, with ports clk50mhz, reset and q[15:0].

Verification
REQ-031 SHALL cover reset mid-RUN with 3 slots active: reset=0 -> same-cycle enemy_act=0, state=0, speed=1.
REQ-032 SHALL cover N_SLOTS=4 with 4*270 RUN ticks: start -> four spawns at ticks 270/540/810/1080, each with y=0 and x one of {197,279,361}.
REQ-033 SHALL cover a slot at y=618 with speed=2: one tick -> enemy_act[i]=0, with score +1 if RACE_SCORE_EN.
REQ-034 SHALL cover 300*7+300 RUN ticks -> speed=8 and held at 8.
REQ-035 SHALL cover player at (279,357) with an enemy in lane 1 reaching y=237 -> crash=1 one cycle after the overlap, state=2, y frozen on later ticks.
REQ-036 SHALL cover all lanes blocked at y<121 when the counter reaches 270 -> no spawn; the counter holds at 270 and the car spawns on the first tick with a clear lane.
